// File: rtl/rca16_wide_add_seq.sv
// Multi-cycle wide adder/subtractor: one shared 16-bit ripple-carry slice is
// stepped LSB-first over WORDS slices, with the slice carry held in a register.

module rca16 (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        cin,
   output logic [15:0] s,
   output logic        co
);

   logic [16:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < 16; i++) begin
         s[i]   = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
      co = c[16];
   end

endmodule

module rca16_wide_add_seq #(
   parameter int unsigned WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [16*WORDS-1:0]   a,
   input  logic [16*WORDS-1:0]   b,
   input  logic                  sub,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [16*WORDS-1:0]   sum,
   output logic                  cout,
   output logic                  ovf
);

   localparam int unsigned W  = 16 * WORDS;
   localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [IW-1:0]   idx;
   logic            carry;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [15:0]     a_sl;
   logic [15:0]     b_sl;
   logic [15:0]     s_sl;
   logic            co_sl;

   // B is stored already inverted for subtraction, so the slice only adds.
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int unsigned w = 0; w < WORDS; w++) begin
         if (idx == IW'(w)) begin
            a_sl = a_q[16*w +: 16];
            b_sl = b_q[16*w +: 16];
         end
      end
   end

   rca16 u_slice (
      .x   (a_sl),
      .y   (b_sl),
      .cin (carry),
      .s   (s_sl),
      .co  (co_sl)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         carry     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= sub ? ~b : b;
                  carry    <= sub;
                  idx      <= '0;
                  sum      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               for (int unsigned w = 0; w < WORDS; w++) begin
                  if (idx == IW'(w)) sum[16*w +: 16] <= s_sl;
               end
               carry <= co_sl;
               if (idx == LAST) begin
                  cout      <= co_sl;
                  ovf       <= (a_q[W-1] == b_q[W-1]) && (s_sl[15] != a_q[W-1]);
                  idx       <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rca16_wide_add_seq.sv
// Directed bench for rca16_wide_add_seq: WORDS=4 vector table plus
// backpressure, mid-run reset, and a WORDS=1 instance.

module tb_rca16_wide_add_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
   logic [63:0] a, b, sum;
   logic        in_valid1, in_ready1, sub1, out_valid1, out_ready1, cout1, ovf1;
   logic [15:0] a1, b1, sum1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rca16_wide_add_seq #(.WORDS(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   rca16_wide_add_seq #(.WORDS(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .ovf(ovf1)
   );

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        sub;
      logic [63:0] s;
      logic        c;
      logic        v;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Leaves the bench at the negedge after the accept edge.
   task automatic start_op(input logic [63:0] av, input logic [63:0] bv, input logic sv);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_before_accept", in_ready, 1);
      a = av; b = bv; sub = sv; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("in_ready_in_run", in_ready, 0);
      chk("out_valid_in_run", out_valid, 0);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("out_valid_after_handoff", out_valid, 0);
      chk("in_ready_after_handoff", in_ready, 1);
   endtask

   task automatic run1(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                       input logic [15:0] es, input logic ec, input logic ev);
      int n;
      @(negedge clk);
      chk("w1_in_ready", in_ready1, 1);
      a1 = av; b1 = bv; sub1 = sv; in_valid1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;
      n = 0;
      while (!out_valid1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("w1_latency", n, 1);
      chk("w1_sum", sum1, es);
      chk("w1_cout", cout1, ec);
      chk("w1_ovf", ovf1, ev);
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      chk("w1_out_valid_drop", out_valid1, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
      vecs[1] = '{64'h0, 64'h1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
      vecs[2] = '{64'h5, 64'h3, 1'b1, 64'h2, 1'b1, 1'b0};
      vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
      vecs[4] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
      vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0,
                  64'h2345_6789_ABCD_F001, 1'b0, 1'b0};
      vecs[6] = '{64'h0000_0000_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0,
                  64'h0000_0001_0000_0000, 1'b0, 1'b0};
      vecs[7] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 64'h0, 1'b1, 1'b0};
      vecs[8] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
      vecs[9] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                  64'h8000_0000_0000_0000, 1'b0, 1'b1};

      rst = 1'b1; in_valid = 0; out_ready = 0; sub = 0; a = '0; b = '0;
      in_valid1 = 0; out_ready1 = 0; sub1 = 0; a1 = '0; b1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_w1_in_ready", in_ready1, 1);
      chk("rst_w1_out_valid", out_valid1, 0);

      for (int i = 0; i < 10; i++) begin
         start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
         wait_done(n);
         chk($sformatf("v%0d_latency", i), n, 4);
         chk($sformatf("v%0d_sum", i), sum, vecs[i].s);
         chk($sformatf("v%0d_cout", i), cout, vecs[i].c);
         chk($sformatf("v%0d_ovf", i), ovf, vecs[i].v);
         handoff();
      end

      // Backpressure: result held while inputs churn
      start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
      wait_done(n);
      chk("bp_latency", n, 4);
      for (int k = 0; k < 5; k++) begin
         in_valid = k[0];
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         sub = k[1];
         @(negedge clk);
         chk("bp_sum", sum, 64'h8000_0000_0000_0000);
         chk("bp_cout", cout, 0);
         chk("bp_ovf", ovf, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      handoff();

      // Leave cout=1 so the reset clear is observable
      start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
      wait_done(n);
      chk("pre_rst_cout", cout, 1);
      handoff();

      // Reset after two slices written
      start_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("partial_sum", sum, 64'h0000_0000_ABCD_F001);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sum", sum, 0);
      chk("midrst_cout", cout, 0);
      chk("midrst_ovf", ovf, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("aborted_not_presented", out_valid, 0);
      end
      start_op(64'h1234, 64'h1, 1'b0);
      wait_done(n);
      chk("post_rst_latency", n, 4);
      chk("post_rst_sum", sum, 64'h1235);
      chk("post_rst_cout", cout, 0);
      handoff();

      // WORDS=1 build
      run1(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run1(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run1(16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
